// File: rtl/busca_instrucao.sv
// Instruction fetch stage: requests one instruction word at the current PC.
// It holds the word for the decoder until the stage is released, then moves
// the PC to the next sequential, branch or jump address.
// Optional feature: define BUSCA_CONTADOR_EN to build the delivered-instruction
// counter (contador_instr). Without it the counter output is tied to zero.
module busca_instrucao #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        desvio,
  input  logic [15:0] imediato,
  input  logic        salto,
  input  logic [25:0] endereco_salto,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] contador_instr
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] BUSCA   = 2'd1;
  localparam logic [1:0] ENTREGA = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        leave_entrega;

  // Sequential successor; all arithmetic wraps modulo 2^32.
  assign pc4      = pc + 32'd4;
  assign pc4_out  = pc4;
  assign pc_out   = pc;
  assign mem_addr = pc;

  // The stage is released only in ENTREGA when the decoder is not stalling.
  assign leave_entrega = (state == ENTREGA) && !stall;

  // Next PC: jump beats branch, branch offset is a sign-extended word count.
  always_comb begin
    branch_off = {{14{imediato[15]}}, imediato, 2'b00};
    next_pc    = pc4;
    if (salto) begin
      next_pc = {pc4[31:28], endereco_salto, 2'b00};
    end else if (desvio) begin
      next_pc = pc4 + branch_off;
    end else begin
      next_pc = pc4;
    end
  end

  // Fetch sequencing: idle once after reset, wait for memory, then hold.
  always_comb begin
    state_nxt = state;
    case (state)
      OCIOSO: begin
        state_nxt = BUSCA;
      end
      BUSCA: begin
        if (mem_ready) begin
          state_nxt = ENTREGA;
        end else begin
          state_nxt = BUSCA;
        end
      end
      ENTREGA: begin
        if (stall) begin
          state_nxt = ENTREGA;
        end else begin
          state_nxt = BUSCA;
        end
      end
      default: begin
        state_nxt = OCIOSO;
      end
    endcase
  end

  // State, PC, captured word and registered handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= OCIOSO;
      pc          <= PC_RESET;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_valid <= (state_nxt == ENTREGA);
      mem_req     <= (state_nxt == BUSCA);
      if ((state == BUSCA) && mem_ready) begin
        instr <= mem_rdata;
      end
      if (leave_entrega) begin
        pc <= next_pc;
      end
    end
  end

`ifdef BUSCA_CONTADOR_EN
  logic [31:0] contador;

  // Counts instructions the decoder has consumed; wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador <= 32'h0000_0000;
    end else if (leave_entrega) begin
      contador <= contador + 32'd1;
    end
  end

  assign contador_instr = contador;
`else
  assign contador_instr = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao. Two instances share all inputs:
// dut_a resets to 0, dut_b resets to 32'hF000_0010 so jump/wrap paths with a
// non-zero upper nibble are reachable. The monitor checks every delivery of
// dut_a against expectations queued by the stimulus.
module tb_busca_instrucao;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        desvio;
  logic [15:0] imediato;
  logic        salto;
  logic [25:0] endereco_salto;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        mem_req_a, instr_valid_a;
  logic [31:0] mem_addr_a, instr_a, pc_out_a, pc4_out_a, cnt_a;
  logic        mem_req_b, instr_valid_b;
  logic [31:0] mem_addr_b, instr_b, pc_out_b, pc4_out_b, cnt_b;

  int errors = 0;
  int checks = 0;
  int deliv  = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];

  busca_instrucao #(.PC_RESET(32'h0000_0000)) dut_a (
    .clock(clock), .reset_n(reset_n), .stall(stall), .desvio(desvio),
    .imediato(imediato), .salto(salto), .endereco_salto(endereco_salto),
    .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .instr(instr_a), .instr_valid(instr_valid_a),
    .pc_out(pc_out_a), .pc4_out(pc4_out_a), .contador_instr(cnt_a)
  );

  busca_instrucao #(.PC_RESET(32'hF000_0010)) dut_b (
    .clock(clock), .reset_n(reset_n), .stall(stall), .desvio(desvio),
    .imediato(imediato), .salto(salto), .endereco_salto(endereco_salto),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .instr(instr_b), .instr_valid(instr_valid_b),
    .pc_out(pc_out_b), .pc4_out(pc4_out_b), .contador_instr(cnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_count(input int n);
`ifdef BUSCA_CONTADOR_EN
    return n;
`else
    return 32'h0000_0000;
`endif
  endfunction

  // One fetch: starts at the negedge after the previous release, expects a
  // request at exp_a/exp_b, keeps memory busy for 'waits' cycles, answers.
  task automatic fetch(input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input logic [31:0] data, input int waits);
    @(negedge clock);
    desvio = 1'b0;
    salto  = 1'b0;
    chk("req_a", {31'd0, mem_req_a}, 32'd1);
    chk("addr_a", mem_addr_a, exp_a);
    chk("addr_b", mem_addr_b, exp_b);
    chk("valid_in_busca", {31'd0, instr_valid_a}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      chk("req_wait", {31'd0, mem_req_a}, 32'd1);
      chk("addr_wait", mem_addr_a, exp_a);
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    exp_pc_q.push_back(exp_a);
    exp_ins_q.push_back(data);
    @(negedge clock);
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
  endtask

  // Monitor: on each new delivery of dut_a, pop and compare.
  initial begin
    logic prev_valid;
    logic [31:0] e_pc, e_ins;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (instr_valid_a && !prev_valid) begin
        if (exp_pc_q.size() == 0) begin
          chk("unexpected_delivery", 32'd1, 32'd0);
        end else begin
          e_pc  = exp_pc_q.pop_front();
          e_ins = exp_ins_q.pop_front();
          chk("instr", instr_a, e_ins);
          chk("pc_out", pc_out_a, e_pc);
          chk("pc4_out", pc4_out_a, e_pc + 32'd4);
          chk("req_in_entrega", {31'd0, mem_req_a}, 32'd0);
          chk("cnt_at_delivery", cnt_a, exp_count(deliv));
          deliv++;
        end
      end
      prev_valid = instr_valid_a;
    end
  end

  // Stimulus
  initial begin
    reset_n = 1'b0; stall = 1'b0; desvio = 1'b0; imediato = 16'h0000;
    salto = 1'b0; endereco_salto = 26'h000_0000;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req", {31'd0, mem_req_a}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_a}, 32'd0);
    chk("rst_instr", instr_a, 32'h0000_0000);
    chk("rst_pc", pc_out_a, 32'h0000_0000);
    chk("rst_pc4", pc4_out_a, 32'h0000_0004);
    chk("rst_cnt", cnt_a, 32'h0000_0000);
    chk("rst_pc_b", pc_out_b, 32'hF000_0010);
    mem_ready = 1'b0;
    reset_n = 1'b1;
    // OCIOSO ignores mem_ready
    mem_ready = 1'b1;
    #1 mem_ready = 1'b0;

    // Jump and branch both set at pc 0 / F000_0010: jump wins.
    fetch(32'h0000_0000, 32'hF000_0010, 32'hAAAA_0001, 0);
    salto = 1'b1; desvio = 1'b1; endereco_salto = 26'h000_0040; imediato = 16'h0005;
    fetch(32'h0000_0100, 32'hF000_0100, 32'hAAAA_0002, 0);
    // Branch -1 word: self loop.
    desvio = 1'b1; imediato = 16'hFFFF;
    fetch(32'h0000_0100, 32'hF000_0100, 32'hAAAA_0003, 1);
    // Branch +3 words.
    desvio = 1'b1; imediato = 16'h0003;
    fetch(32'h0000_0110, 32'hF000_0110, 32'hAAAA_0004, 0);
    // Jump to the top word of dut_b's region, then wrap to 0.
    salto = 1'b1; endereco_salto = 26'h3FF_FFFF;
    fetch(32'h0FFF_FFFC, 32'hFFFF_FFFC, 32'hAAAA_0005, 0);
    chk("pc_b_top", pc_out_b, 32'hFFFF_FFFC);
    chk("pc4_b_wrap", pc4_out_b, 32'h0000_0000);
    fetch(32'h1000_0000, 32'h0000_0000, 32'hAAAA_0006, 0);

    // Stall 5 cycles in ENTREGA; mem_ready there must be ignored.
    stall = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_instr", instr_a, 32'hAAAA_0006);
      chk("stall_pc", pc_out_a, 32'h1000_0000);
      chk("stall_valid", {31'd0, instr_valid_a}, 32'd1);
      chk("stall_req", {31'd0, mem_req_a}, 32'd0);
    end
    stall = 1'b0; mem_ready = 1'b0;
    fetch(32'h1000_0004, 32'h0000_0004, 32'hAAAA_0007, 2);

    // Memory silent 10 cycles in BUSCA, then asynchronous reset.
    @(negedge clock);
    chk("busy_addr", mem_addr_a, 32'h1000_0008);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("busy_req", {31'd0, mem_req_a}, 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req_a}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid_a}, 32'd0);
    chk("arst_instr", instr_a, 32'h0000_0000);
    chk("arst_pc", pc_out_a, 32'h0000_0000);
    chk("arst_addr", mem_addr_a, 32'h0000_0000);
    chk("arst_cnt", cnt_a, 32'h0000_0000);
    chk("arst_pc_b", pc_out_b, 32'hF000_0010);
    deliv = 0;
    mem_ready = 1'b1; mem_rdata = 32'h6666_6666;
    @(negedge clock);
    @(negedge clock);
    mem_ready = 1'b0;
    reset_n = 1'b1;

    // Straight-line fetch after reset: 0, 4, 8 with an immediately ready memory.
    fetch(32'h0000_0000, 32'hF000_0010, 32'hBBBB_0000, 0);
    fetch(32'h0000_0004, 32'hF000_0014, 32'hBBBB_0004, 0);
    fetch(32'h0000_0008, 32'hF000_0018, 32'hBBBB_0008, 0);
    @(negedge clock);
    chk("cnt_after_3", cnt_a, exp_count(3));
    chk("addr_after_3", mem_addr_a, 32'h0000_000C);
    chk("queue_drained", exp_pc_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
